ann_weight_port: RTL and testbench

Responder-side weight interface of the ANN. It accepts the serial weight upload stream (Weight_Save_enable/Weight_in) into a 40-entry weight store and serves those weights to the compute core. It accepts updated weights from the training logic. It streams the updated weights back out on New_weight_out under Weight_Load_enable, one word per clock. It is the counterpart of the host-side upload/download sequence.

---
 rtl/ann_pkg.sv | 21 ++
 rtl/ann_weight_port_if.sv | 21 ++
 rtl/ann_weight_ram.sv | 47 ++++
 rtl/ann_weight_port.sv | 142 ++++++++++++++
 tb/tb_ann_weight_port.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ann_pkg.sv
// Shared sizing, types and FSM encoding for the ANN weight port.
package ann_pkg;
    localparam int INPUT_SIZE = 13;
    localparam int WORD_W     = INPUT_SIZE * 12;
    localparam int INPUT_NUM  = 4;
    localparam int NEURON_NUM = 8;
    localparam int WEIGHT_NUM = INPUT_NUM * NEURON_NUM + NEURON_NUM;
    localparam int ADDR_W     = $clog2(WEIGHT_NUM);

    typedef logic [WORD_W-1:0] weight_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        LOAD = 2'd2
    } state_e;

    localparam addr_t LAST_IDX = addr_t'(WEIGHT_NUM - 1);
    localparam addr_t NUM_IDX  = addr_t'(WEIGHT_NUM);
endpackage

// File: rtl/ann_weight_port_if.sv
// Upload/download stream and status signals between the host sequencer and the weight port.
interface ann_weight_port_if;
    ann_pkg::weight_t Weight_in;
    logic             Weight_Save_enable;
    logic             Weight_Load_enable;
    ann_pkg::weight_t New_weight_out;
    logic             Load_valid;
    logic             Save_done;
    logic             Weights_valid;
    logic             Err;

    modport master (
        output Weight_in, Weight_Save_enable, Weight_Load_enable,
        input  New_weight_out, Load_valid, Save_done, Weights_valid, Err
    );

    modport slave (
        input  Weight_in, Weight_Save_enable, Weight_Load_enable,
        output New_weight_out, Load_valid, Save_done, Weights_valid, Err
    );
endinterface

// File: rtl/ann_weight_ram.sv
// Weight store: one synchronous write port, two registered read ports (core, download).
module ann_weight_ram
    import ann_pkg::*;
(
    input  logic    clk,
    input  logic    srst,
    input  logic    we,
    input  addr_t   waddr,
    input  weight_t wdata,
    input  addr_t   core_addr,
    output weight_t core_data,
    input  logic    dl_en,
    input  addr_t   dl_addr,
    output weight_t dl_data
);
    weight_t mem [WEIGHT_NUM];
    weight_t core_data_q;
    weight_t dl_data_q;

    // Contents survive reset; only the read registers are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            core_data_q <= '0;
        end else if (core_addr < NUM_IDX) begin
            core_data_q <= mem[core_addr];
        end else begin
            core_data_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            dl_data_q <= '0;
        end else if (dl_en) begin
            dl_data_q <= mem[dl_addr];
        end
    end

    assign core_data = core_data_q;
    assign dl_data   = dl_data_q;
endmodule

// File: rtl/ann_weight_port.sv
// Responder-side weight port: serial upload, streamed download, core reads and training updates.
module ann_weight_port
    import ann_pkg::*;
(
    input  logic    Clk,
    input  logic    Reset_h,
    ann_weight_port_if.slave wif,
    input  addr_t   Core_rd_addr,
    output weight_t Core_rd_data,
    input  logic    Upd_we,
    input  addr_t   Upd_addr,
    input  weight_t Upd_data
);
    state_e state_q, state_d;
    addr_t  wr_ptr_q, wr_ptr_d;
    addr_t  rd_ptr_q, rd_ptr_d;
    logic   load_valid_q, load_valid_d;
    logic   save_done_q, save_done_d;
    logic   weights_valid_q, weights_valid_d;
    logic   err_q, err_d;

    logic    save_we, upd_ok, dl_en, err_set;
    logic    ram_we;
    addr_t   ram_waddr;
    weight_t ram_wdata;

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            load_valid_q    <= 1'b0;
            save_done_q     <= 1'b0;
            weights_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            load_valid_q    <= load_valid_d;
            save_done_q     <= save_done_d;
            weights_valid_q <= weights_valid_d;
            err_q           <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        load_valid_d    = load_valid_q;
        save_done_d     = 1'b0;
        weights_valid_d = weights_valid_q;
        err_set         = 1'b0;
        save_we         = 1'b0;
        dl_en           = 1'b0;
        upd_ok          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wif.Weight_Save_enable && wif.Weight_Load_enable) begin
                    err_set = 1'b1;
                end else if (wif.Weight_Save_enable) begin
                    save_we         = 1'b1;
                    wr_ptr_d        = wr_ptr_q + addr_t'(1);
                    weights_valid_d = 1'b0;
                    state_d         = SAVE;
                end else if (wif.Weight_Load_enable) begin
                    dl_en        = 1'b1;
                    rd_ptr_d     = rd_ptr_q + addr_t'(1);
                    load_valid_d = 1'b1;
                    state_d      = LOAD;
                    err_set      = !weights_valid_q;
                end
            end
            SAVE: begin
                if (wif.Weight_Load_enable) begin
                    err_set = 1'b1;
                end else if (wif.Weight_Save_enable) begin
                    save_we = 1'b1;
                    if (wr_ptr_q == LAST_IDX) begin
                        save_done_d     = 1'b1;
                        weights_valid_d = 1'b1;
                        wr_ptr_d        = '0;
                        state_d         = IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + addr_t'(1);
                    end
                end
            end
            LOAD: begin
                if (wif.Weight_Save_enable && wif.Weight_Load_enable) begin
                    err_set = 1'b1;
                end else if (wif.Weight_Load_enable) begin
                    // rd_ptr parks at WEIGHT_NUM once the last word is out
                    if (rd_ptr_q < NUM_IDX) begin
                        dl_en        = 1'b1;
                        rd_ptr_d     = rd_ptr_q + addr_t'(1);
                        load_valid_d = 1'b1;
                    end else begin
                        load_valid_d = 1'b0;
                    end
                end else begin
                    err_set      = wif.Weight_Save_enable;
                    state_d      = IDLE;
                    rd_ptr_d     = '0;
                    load_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Training writes share the single write port and lose to an upload word.
        upd_ok = Upd_we && (state_q == IDLE) && (Upd_addr < NUM_IDX) && !save_we;
        if (Upd_we && !upd_ok) begin
            err_set = 1'b1;
        end
        err_d = err_q | err_set;
    end

    assign ram_we    = save_we | upd_ok;
    assign ram_waddr = save_we ? wr_ptr_q : Upd_addr;
    assign ram_wdata = save_we ? wif.Weight_in : Upd_data;

    ann_weight_ram u_ram (
        .clk       (Clk),
        .srst      (Reset_h),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (ram_wdata),
        .core_addr (Core_rd_addr),
        .core_data (Core_rd_data),
        .dl_en     (dl_en),
        .dl_addr   (rd_ptr_q),
        .dl_data   (wif.New_weight_out)
    );

    assign wif.Load_valid    = load_valid_q;
    assign wif.Save_done     = save_done_q;
    assign wif.Weights_valid = weights_valid_q;
    assign wif.Err           = err_q;
endmodule

// File: tb/tb_ann_weight_port.sv
// Directed bench for ann_weight_port: core-read vector table plus upload/download sequences.
module tb_ann_weight_port;
    import ann_pkg::*;

    logic    Clk;
    logic    Reset_h;
    addr_t   Core_rd_addr;
    weight_t Core_rd_data;
    logic    Upd_we;
    addr_t   Upd_addr;
    weight_t Upd_data;

    ann_weight_port_if wif ();

    ann_weight_port dut (
        .Clk          (Clk),
        .Reset_h      (Reset_h),
        .wif          (wif),
        .Core_rd_addr (Core_rd_addr),
        .Core_rd_data (Core_rd_data),
        .Upd_we       (Upd_we),
        .Upd_addr     (Upd_addr),
        .Upd_data     (Upd_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        addr_t   addr;
        weight_t exp;
    } core_vec_t;

    core_vec_t cv [6];
    weight_t   dl_buf [WEIGHT_NUM];
    logic      dl_vld [WEIGHT_NUM];
    int        n_checks = 0;
    int        n_errors = 0;
    int        done_cnt;
    int        done_at;
    int        edge_no;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input weight_t act, input weight_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic do_reset();
        Reset_h = 1'b1;
        wif.Weight_Save_enable = 1'b0;
        wif.Weight_Load_enable = 1'b0;
        wif.Weight_in = '0;
        Upd_we = 1'b0;
        Upd_addr = '0;
        Upd_data = '0;
        Core_rd_addr = '0;
        tick();
        tick();
        Reset_h = 1'b0;
    endtask

    task automatic clear_done();
        done_cnt = 0;
        done_at  = -1;
        edge_no  = 0;
    endtask

    task automatic save_words(input int first_val, input int n);
        for (int i = 0; i < n; i++) begin
            wif.Weight_in = weight_t'(first_val + i);
            wif.Weight_Save_enable = 1'b1;
            tick();
            if (wif.Save_done) begin
                done_cnt++;
                done_at = edge_no;
            end
            edge_no++;
        end
        wif.Weight_Save_enable = 1'b0;
    endtask

    task automatic download_all();
        wif.Weight_Load_enable = 1'b1;
        for (int k = 0; k < WEIGHT_NUM; k++) begin
            tick();
            dl_buf[k] = wif.New_weight_out;
            dl_vld[k] = wif.Load_valid;
        end
        wif.Weight_Load_enable = 1'b0;
        tick();
    endtask

    task automatic core_read(input addr_t a);
        Core_rd_addr = a;
        tick();
    endtask

    initial begin
        cv[0] = '{addr: 6'd5,  exp: weight_t'(6)};
        cv[1] = '{addr: 6'd0,  exp: weight_t'(1)};
        cv[2] = '{addr: 6'd39, exp: weight_t'(40)};
        cv[3] = '{addr: 6'd20, exp: weight_t'(21)};
        cv[4] = '{addr: 6'd40, exp: weight_t'(0)};
        cv[5] = '{addr: 6'd63, exp: weight_t'(0)};

        // Reset state
        do_reset();
        check("rst_new_weight_out", wif.New_weight_out, '0);
        check("rst_core_rd_data", Core_rd_data, '0);
        check("rst_load_valid", weight_t'(wif.Load_valid), '0);
        check("rst_save_done", weight_t'(wif.Save_done), '0);
        check("rst_weights_valid", weight_t'(wif.Weights_valid), '0);
        check("rst_err", weight_t'(wif.Err), '0);

        // Full upload of k+1
        clear_done();
        save_words(1, WEIGHT_NUM);
        check("up_done_cnt", weight_t'(done_cnt), weight_t'(1));
        check("up_done_at", weight_t'(done_at), weight_t'(39));
        check("up_weights_valid", weight_t'(wif.Weights_valid), weight_t'(1));
        tick();
        check("up_done_one_cycle", weight_t'(wif.Save_done), '0);
        check("up_err", weight_t'(wif.Err), '0);

        // Core read table
        for (int i = 0; i < 6; i++) begin
            core_read(cv[i].addr);
            check($sformatf("core_rd[%0d]", cv[i].addr), Core_rd_data, cv[i].exp);
        end

        // Download with saturation on the 41st cycle
        wif.Weight_Load_enable = 1'b1;
        for (int k = 0; k < WEIGHT_NUM; k++) begin
            tick();
            check($sformatf("dl_word[%0d]", k), wif.New_weight_out, weight_t'(k + 1));
            check($sformatf("dl_valid[%0d]", k), weight_t'(wif.Load_valid), weight_t'(1));
        end
        tick();
        check("dl_sat_valid", weight_t'(wif.Load_valid), '0);
        check("dl_sat_word", wif.New_weight_out, weight_t'(40));
        wif.Weight_Load_enable = 1'b0;
        tick();
        check("dl_end_valid", weight_t'(wif.Load_valid), '0);
        check("dl_end_hold", wif.New_weight_out, weight_t'(40));
        check("dl_end_err", weight_t'(wif.Err), '0);

        // Training update in IDLE, then read back both ways
        Upd_we = 1'b1; Upd_addr = 6'd7; Upd_data = weight_t'(12'hABC);
        tick();
        Upd_we = 1'b0;
        core_read(6'd7);
        check("upd_core_rd7", Core_rd_data, weight_t'(12'hABC));
        check("upd_err", weight_t'(wif.Err), '0);
        download_all();
        check("upd_dl7", dl_buf[7], weight_t'(12'hABC));
        check("upd_dl6", dl_buf[6], weight_t'(7));
        check("upd_dl8", dl_buf[8], weight_t'(9));

        // Out-of-range update
        Upd_we = 1'b1; Upd_addr = 6'd45; Upd_data = weight_t'(12'h555);
        tick();
        Upd_we = 1'b0;
        check("upd_oor_err", weight_t'(wif.Err), weight_t'(1));
        core_read(6'd7);
        check("upd_oor_rd7", Core_rd_data, weight_t'(12'hABC));
        core_read(6'd39);
        check("upd_oor_rd39", Core_rd_data, weight_t'(40));

        // Paused upload
        do_reset();
        check("pause_rst_err", weight_t'(wif.Err), '0);
        clear_done();
        save_words(1, 20);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_no_done", weight_t'(wif.Save_done), '0);
        end
        save_words(21, 20);
        check("pause_done_cnt", weight_t'(done_cnt), weight_t'(1));
        check("pause_done_at", weight_t'(done_at), weight_t'(39));
        check("pause_err", weight_t'(wif.Err), '0);
        core_read(6'd20);
        check("pause_rd20", Core_rd_data, weight_t'(21));
        core_read(6'd7);
        check("pause_rd7", Core_rd_data, weight_t'(8));

        // Save+Load collision mid-upload and mid-download
        do_reset();
        clear_done();
        save_words(500, 3);
        wif.Weight_in = weight_t'(999);
        wif.Weight_Save_enable = 1'b1;
        wif.Weight_Load_enable = 1'b1;
        tick();
        wif.Weight_Save_enable = 1'b0;
        wif.Weight_Load_enable = 1'b0;
        check("both_save_err", weight_t'(wif.Err), weight_t'(1));
        check("both_save_lv", weight_t'(wif.Load_valid), '0);
        save_words(503, 37);
        check("both_save_done_cnt", weight_t'(done_cnt), weight_t'(1));
        check("both_save_done_at", weight_t'(done_at), weight_t'(39));
        core_read(6'd3);
        check("both_save_rd3", Core_rd_data, weight_t'(503));
        wif.Weight_Load_enable = 1'b1;
        tick();
        check("both_load_w0", wif.New_weight_out, weight_t'(500));
        wif.Weight_Save_enable = 1'b1;
        tick();
        check("both_load_hold", wif.New_weight_out, weight_t'(500));
        wif.Weight_Save_enable = 1'b0;
        tick();
        check("both_load_w1", wif.New_weight_out, weight_t'(501));
        wif.Weight_Load_enable = 1'b0;
        tick();

        // Load request with no valid weight set
        do_reset();
        wif.Weight_Load_enable = 1'b1;
        tick();
        wif.Weight_Load_enable = 1'b0;
        check("early_load_err", weight_t'(wif.Err), weight_t'(1));
        check("early_load_lv", weight_t'(wif.Load_valid), weight_t'(1));
        tick();

        // Reset mid-upload, then a clean upload of 100+k
        do_reset();
        clear_done();
        save_words(900, 10);
        do_reset();
        check("abort_wv", weight_t'(wif.Weights_valid), '0);
        clear_done();
        save_words(100, WEIGHT_NUM);
        check("abort_done_cnt", weight_t'(done_cnt), weight_t'(1));
        check("abort_done_at", weight_t'(done_at), weight_t'(39));
        check("abort_wv_set", weight_t'(wif.Weights_valid), weight_t'(1));
        check("abort_err", weight_t'(wif.Err), '0);
        download_all();
        for (int k = 0; k < WEIGHT_NUM; k++) begin
            check($sformatf("abort_dl[%0d]", k), dl_buf[k], weight_t'(100 + k));
            check($sformatf("abort_vld[%0d]", k), weight_t'(dl_vld[k]), weight_t'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
